// File: rtl/ddr3_traffic_checker.sv
// Write-then-read memory traffic checker: writes an address-derived pattern, reads it back and counts mismatches.
// Define DDR3_TRAFFIC_ERR_LOG_EN to capture the address and read data of the first mismatch of each run.
module ddr3_traffic_checker #(
  parameter int DATA_W          = 128,
  parameter int ID_W            = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [ID_W-1:0]     num_words_i,
  input  logic [1:0]          mode_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [31:0]         first_err_addr_o,
  output logic [DATA_W-1:0]   first_err_data_o,
  output logic [DATA_W/8-1:0] inport_wr_o,
  output logic                inport_rd_o,
  output logic [31:0]         inport_addr_o,
  output logic [DATA_W-1:0]   inport_write_data_o,
  output logic [ID_W-1:0]     inport_req_id_o,
  input  logic                inport_accept_i,
  input  logic                inport_ack_i,
  input  logic                inport_error_i,
  input  logic [ID_W-1:0]     inport_resp_id_i,
  input  logic [DATA_W-1:0]   inport_read_data_i
);
  localparam int          LANES  = DATA_W / 32;
  localparam logic [31:0] BYTES  = 32'(DATA_W / 8);
  localparam logic [31:0] DW32   = 32'(DATA_W);
  localparam logic [3:0]  MAX_OS = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [ID_W-1:0]   count_q, count_d;
  logic [ID_W-1:0]   word_q, word_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        os_q, os_d;
  logic [15:0]       err_q, err_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;

  logic              start_go, req_v, acc, ack_v, rd_phase, mismatch, last_word;
  logic [31:0]       req_addr, resp_addr;
  logic [DATA_W-1:0] exp_data;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] mode, input logic [31:0] a);
    logic [31:0] idx;
    pattern = '0;
    idx = (a / BYTES) % DW32;
    for (int k = 0; k < LANES; k++) begin
      case (mode)
        2'd0:    pattern[k*32 +: 32] = a;
        2'd1:    pattern[k*32 +: 32] = ~a;
        2'd3:    pattern[k*32 +: 32] = a ^ (32'h9E3779B9 * 32'(k + 1));
        default: pattern[k*32 +: 32] = '0;
      endcase
    end
    if (mode == 2'd2) begin
      for (int i = 0; i < DATA_W; i++) pattern[i] = (idx == 32'(i));
    end
  endfunction

  assign start_go  = start_i && (state_q == IDLE || state_q == DONE);
  assign req_v     = (state_q == WRITE || state_q == READ) && (word_q < count_q) && (os_q < MAX_OS);
  assign acc       = req_v && inport_accept_i;
  // Acks that arrive with nothing outstanding (e.g. from before a reset) are dropped entirely.
  assign ack_v     = inport_ack_i && (os_q != 4'd0);
  assign rd_phase  = (state_q == READ) || (state_q == RDRAIN);
  assign last_word = (word_q + 1'b1) == count_q;
  assign req_addr  = base_q + 32'(word_q) * BYTES;
  assign resp_addr = base_q + 32'(inport_resp_id_i) * BYTES;
  assign exp_data  = pattern(mode_q, resp_addr);
  assign mismatch  = ack_v && rd_phase && (inport_read_data_i != exp_data);

  assign inport_wr_o         = (req_v && state_q == WRITE) ? '1 : '0;
  assign inport_rd_o         = req_v && (state_q == READ);
  assign inport_addr_o       = req_v ? req_addr : '0;
  assign inport_write_data_o = (req_v && state_q == WRITE) ? pattern(mode_q, req_addr) : '0;
  assign inport_req_id_o     = req_v ? word_q : '0;
  assign busy_o              = (state_q == WRITE) || (state_q == WDRAIN) || rd_phase;
  assign done_o              = done_q;
  assign pass_o              = pass_q;
  assign err_count_o         = err_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    word_d  = word_q;
    mode_d  = mode_q;
    os_d    = os_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    if (acc && !ack_v)      os_d = os_q + 4'd1;
    else if (!acc && ack_v) os_d = os_q - 4'd1;
    if (acc) word_d = word_q + 1'b1;
    if ((mismatch || (ack_v && inport_error_i)) && err_q != 16'hFFFF) err_d = err_q + 16'd1;

    case (state_q)
      IDLE, DONE: begin
        if (start_go) begin
          base_d  = base_addr_i;
          count_d = num_words_i;
          mode_d  = mode_i;
          word_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (count_q == '0)          state_d = DONE;
        else if (acc && last_word)  state_d = WDRAIN;
      end
      WDRAIN: begin
        if (os_q == 4'd0) begin
          word_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (acc && last_word) state_d = RDRAIN;
      end
      RDRAIN: begin
        if (os_q == 4'd0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      done_d = 1'b1;
      pass_d = (err_q == 16'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      mode_q  <= '0;
      os_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      os_q    <= os_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

`ifdef DDR3_TRAFFIC_ERR_LOG_EN
  logic [31:0]       ferr_addr_q;
  logic [DATA_W-1:0] ferr_data_q;
  logic              ferr_vld_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      ferr_vld_q  <= 1'b0;
    end else if (start_go) begin
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      ferr_vld_q  <= 1'b0;
    end else if (mismatch && !ferr_vld_q) begin
      ferr_addr_q <= resp_addr;
      ferr_data_q <= inport_read_data_i;
      ferr_vld_q  <= 1'b1;
    end
  end

  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;
`else
  assign first_err_addr_o = '0;
  assign first_err_data_o = '0;
`endif

endmodule
